hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits next to the forwarding unit and resolves the hazards that forwarding cannot: load-use hazards, taken-branch flushes, and the multi-cycle multiply/divide unit. It drives the PC and IF/ID write enables and the IF/ID and ID/EX flush controls. It also keeps a saturating count of stalled cycles.

## Interface
- MUL_LAT, 4, cycles the mul/div unit is busy for a multiply (≥1)
- DIV_LAT, 32, cycles the mul/div unit is busy for a divide (≥1)
- CNT_W, 16, width of stall_count

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
- id_md_read  in  1  ID instruction reads HI/LO or is itself a mul/div
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- md_start  in  1  mul/div instruction is in EX this cycle
- md_is_div  in  1  qualifies md_start: 1 = divide, 0 = multiply
- pc_write  out  1  PC register write enable
- ifid_write  out  1  IF/ID register write enable
- ifid_flush  out  1  IF/ID register loads a NOP
- idex_flush  out  1  ID/EX register loads a bubble
- md_busy  out  1  mul/div unit is busy (registered)
- stall_count  out  CNT_W  cycles with pc_write=0 since reset (saturating)

## Operation
- Two-state FSM: RUN and MD_WAIT. A down-counter md_cnt is sized for max(MUL_LAT, DIV_LAT)-1.
- Control outputs are combinational from the current state and inputs. Priority, highest first:
  1. rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1.
  2. branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1.
  3. MD stall (state MD_WAIT and id_md_read=1): pc_write=0, ifid_write=0, ifid_flush=0, idex_flush=1.
  4. Load-use stall: ex_mem_read=1, ex_rd≠0, and either (id_use_rs and id_rs==ex_rd) or (id_use_rt and id_rt==ex_rd).
     - Outputs as in the MD stall.
  5. Otherwise: pc_write=1, ifid_write=1, both flushes 0.
- Load-use produces exactly one bubble, because the bubble removes the load from EX. The FSM does not track it.
- RUN → MD_WAIT when md_start=1. md_cnt loads DIV_LAT-1 if md_is_div, else MUL_LAT-1. This happens even if branch_taken=1, because the mul/div is older than the branch.
- MD_WAIT: at each edge, if md_cnt==0 go to RUN, else md_cnt decrements.
- md_start in MD_WAIT is ignored; a second mul/div is held in ID by the MD stall.
- md_busy = (state==MD_WAIT).
- stall_count increments on each edge where pc_write=0 and rst=0. It holds at 2^CNT_W-1 and never wraps.

## Timing
- Reset values: state RUN, md_cnt 0, md_busy 0, stall_count 0. Control outputs during reset are as in priority 1.
- rst in any state, including mid-MD_WAIT: the next cycle is RUN, md_busy=0, and the count is cleared.
- Stall and flush outputs respond in the same cycle as their causing inputs (zero latency).
- If md_start is sampled at edge t, md_busy is high for exactly LAT cycles after t (MUL_LAT or DIV_LAT). The first cycle without an MD stall is cycle t+LAT+1.
- An MD stall and a load-use hazard in the same cycle give a single stall; stall_count increments by 1.
- branch_taken during MD_WAIT flushes the front end; md_cnt and md_busy are unaffected.
- A load-use match on ex_rd=0 never stalls.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1.
  - Same cycle: pc_write=0, ifid_write=0, idex_flush=1.
  - Next cycle, with the bubble in EX (ex_mem_read=0): normal outputs; stall_count=1.
- ex_rd=0 with id_rt=0, id_use_rt=1, ex_mem_read=1 → no stall. A match on rt with id_use_rt=0 → no stall.
- Multiply: md_start=1, md_is_div=0 at edge t; id_md_read=1 held.
  - md_busy is high for 4 cycles with pc_write=0 each cycle.
  - pc_write=1 on cycle t+5; stall_count=4.
- Divide (DIV_LAT=32): md_busy is high for 32 cycles. branch_taken pulsed at cycle 10 → ifid_flush=idex_flush=pc_write=1 that cycle, and md_busy is still high until the 32nd cycle.
- rst asserted at cycle 5 of a divide → next cycle md_busy=0, state RUN, stall_count=0. During rst, pc_write=0 and both flushes are 1.
- With CNT_W=4, hold a permanent MD stall for 20 cycles → stall_count saturates at 15 and stays there.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage MIPS core.
// Resolves load-use hazards, taken-branch flushes and mul/div busy stalls,
// and keeps a saturating count of cycles in which the PC was held.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  // Down-counter only has to hold max(MUL_LAT, DIV_LAT)-1.
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MD_CW   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [MD_CW-1:0] MUL_LOAD = MD_CW'(MUL_LAT - 1);
  localparam logic [MD_CW-1:0] DIV_LOAD = MD_CW'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t             state_reg;
  logic [MD_CW-1:0]   md_cnt_reg;
  logic               md_busy_reg;
  logic [CNT_W-1:0]   stall_count_reg;

  logic               load_use;
  logic               md_stall;

  // Front-end controls, resolved in priority order from the current cycle.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs && (id_rs == ex_rd)) ||
                (id_use_rt && (id_rt == ex_rd)));
    md_stall = (state_reg == MD_WAIT) && id_md_read;

    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path instructions in IF and ID are squashed; fetch redirects.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (md_stall || load_use) begin
      // Hold PC and IF/ID, push a bubble into EX.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Mul/div occupancy FSM; a start is honoured even alongside a taken
  // branch because the mul/div is older than the branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      md_cnt_reg  <= '0;
      md_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (md_start) begin
            state_reg   <= MD_WAIT;
            md_cnt_reg  <= md_is_div ? DIV_LOAD : MUL_LOAD;
            md_busy_reg <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_cnt_reg == '0) begin
            state_reg   <= RUN;
            md_busy_reg <= 1'b0;
          end else begin
            md_cnt_reg <= md_cnt_reg - MD_CW'(1);
          end
        end
        default: begin
          state_reg   <= RUN;
          md_cnt_reg  <= '0;
          md_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of held-PC cycles outside reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= '0;
    end else if (!pc_write && (stall_count_reg != CNT_MAX)) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign md_busy     = md_busy_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (16-bit and 4-bit counters)
// share one directed stimulus stream; a cycle-level model checks both on
// every falling edge, and literal expectations pin key moments.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, id_md_read;
  logic       ex_mem_read, branch_taken, md_start, md_is_div;

  logic        pc_write_a, ifid_write_a, ifid_flush_a, idex_flush_a, md_busy_a;
  logic [15:0] stall_count_a;
  logic        pc_write_b, ifid_write_b, ifid_flush_b, idex_flush_b, md_busy_b;
  logic [3:0]  stall_count_b;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // model state: remaining busy cycles and the two counters
  int busy_left = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_read(id_md_read),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .md_start(md_start), .md_is_div(md_is_div),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .md_busy(md_busy_a), .stall_count(stall_count_a)
  );

  hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md_read(id_md_read),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken(branch_taken),
    .md_start(md_start), .md_is_div(md_is_div),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .md_busy(md_busy_b), .stall_count(stall_count_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // expected {pc_write, ifid_write, ifid_flush, idex_flush} for this cycle
  function automatic logic [3:0] expect_ctrl();
    bit hazard;
    bit md_hold;
    hazard  = ex_mem_read && (ex_rd != 0) &&
              ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    md_hold = (busy_left > 0) && id_md_read;
    if (rst)                    return 4'b0011;
    else if (branch_taken)      return 4'b1111;
    else if (hazard || md_hold) return 4'b0001;
    else                        return 4'b1100;
  endfunction

  // model advance at each rising edge
  always @(posedge clk) begin
    logic [3:0] e;
    e = expect_ctrl();
    if (rst) begin
      busy_left <= 0;
      cnt_a     <= 0;
      cnt_b     <= 0;
    end else begin
      if (!e[3]) begin
        if (cnt_a < 65535) cnt_a <= cnt_a + 1;
        if (cnt_b < 15)    cnt_b <= cnt_b + 1;
      end
      if (busy_left > 0)  busy_left <= busy_left - 1;
      else if (md_start)  busy_left <= md_is_div ? 32 : 4;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] e;
    if (checking) begin
      e = expect_ctrl();
      check("a.pc_write",    pc_write_a,    e[3]);
      check("a.ifid_write",  ifid_write_a,  e[2]);
      check("a.ifid_flush",  ifid_flush_a,  e[1]);
      check("a.idex_flush",  idex_flush_a,  e[0]);
      check("a.md_busy",     md_busy_a,     busy_left > 0);
      check("a.stall_count", stall_count_a, cnt_a);
      check("b.pc_write",    pc_write_b,    e[3]);
      check("b.ifid_write",  ifid_write_b,  e[2]);
      check("b.ifid_flush",  ifid_flush_b,  e[1]);
      check("b.idex_flush",  idex_flush_b,  e[0]);
      check("b.md_busy",     md_busy_b,     busy_left > 0);
      check("b.stall_count", stall_count_b, cnt_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_md_read = 0;
    ex_mem_read = 0; branch_taken = 0; md_start = 0; md_is_div = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    checking = 1'b1;
    settle();
    $display("reset: pc_write=%0d ifid_flush=%0d idex_flush=%0d", pc_write_a, ifid_flush_a, idex_flush_a);
    check("rst.pc_write", pc_write_a, 0);
    check("rst.ifid_flush", ifid_flush_a, 1);
    check("rst.idex_flush", idex_flush_a, 1);
    check("rst.md_busy", md_busy_a, 0);
    check("rst.stall_count", stall_count_a, 0);
    tick();
    rst = 1'b0;

    // load-use on rs
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_use_rs = 1;
    settle();
    $display("load-use rs: pc_write=%0d ifid_write=%0d idex_flush=%0d", pc_write_a, ifid_write_a, idex_flush_a);
    check("lu.pc_write", pc_write_a, 0);
    check("lu.ifid_write", ifid_write_a, 0);
    check("lu.idex_flush", idex_flush_a, 1);
    check("lu.ifid_flush", ifid_flush_a, 0);
    tick();
    ex_mem_read = 0;
    settle();
    $display("bubble in EX: pc_write=%0d stall_count=%0d", pc_write_a, stall_count_a);
    check("lu_next.pc_write", pc_write_a, 1);
    check("lu_next.stall_count", stall_count_a, 1);
    tick();

    // rd = 0 never stalls; rt match without use never stalls
    idle(); ex_mem_read = 1; ex_rd = 0; id_rt = 0; id_use_rt = 1;
    settle();
    $display("rd0: pc_write=%0d", pc_write_a);
    check("rd0.pc_write", pc_write_a, 1);
    tick();
    idle(); ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_use_rt = 0;
    settle();
    $display("rt unused: pc_write=%0d", pc_write_a);
    check("rt_unused.pc_write", pc_write_a, 1);
    tick();
    id_use_rt = 1;
    settle();
    $display("rt used: pc_write=%0d", pc_write_a);
    check("rt_used.pc_write", pc_write_a, 0);
    tick();
    idle();

    // multiply from a clean reset
    do_reset();
    md_start = 1; md_is_div = 0; id_md_read = 1;
    settle();
    check("mul_start.pc_write", pc_write_a, 1);
    tick();
    md_start = 0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      $display("mul cycle %0d: md_busy=%0d pc_write=%0d", i, md_busy_a, pc_write_a);
      check("mul.md_busy", md_busy_a, 1);
      check("mul.pc_write", pc_write_a, 0);
      tick();
    end
    settle();
    $display("mul done: md_busy=%0d pc_write=%0d stall_count=%0d", md_busy_a, pc_write_a, stall_count_a);
    check("mul_done.md_busy", md_busy_a, 0);
    check("mul_done.pc_write", pc_write_a, 1);
    check("mul_done.stall_count", stall_count_a, 4);
    tick();
    idle();

    // divide with branch, ignored restart, and coincident load-use
    do_reset();
    md_start = 1; md_is_div = 1; id_md_read = 1;
    tick();
    md_start = 0;
    for (int i = 1; i <= 32; i++) begin
      branch_taken = (i == 10);
      md_start     = (i == 5);
      md_is_div    = (i != 5);
      ex_mem_read  = (i == 15); ex_rd = 5'd3; id_rs = 5'd3; id_use_rs = (i == 15);
      settle();
      $display("div cycle %0d: md_busy=%0d pc_write=%0d ifid_flush=%0d", i, md_busy_a, pc_write_a, ifid_flush_a);
      check("div.md_busy", md_busy_a, 1);
      if (i == 10) begin
        check("div_br.pc_write", pc_write_a, 1);
        check("div_br.ifid_flush", ifid_flush_a, 1);
        check("div_br.idex_flush", idex_flush_a, 1);
      end else begin
        check("div.pc_write", pc_write_a, 0);
      end
      if (i == 25) check("sat_mid.stall_count", stall_count_b, 15);
      tick();
    end
    idle(); id_md_read = 1;
    settle();
    $display("div done: md_busy=%0d pc_write=%0d count16=%0d count4=%0d", md_busy_a, pc_write_a, stall_count_a, stall_count_b);
    check("div_done.md_busy", md_busy_a, 0);
    check("div_done.pc_write", pc_write_a, 1);
    check("div_done.stall_count", stall_count_a, 31);
    check("sat_end.stall_count", stall_count_b, 15);
    tick();
    idle();

    // reset in the middle of a divide
    do_reset();
    md_start = 1; md_is_div = 1; id_md_read = 1;
    tick();
    md_start = 0;
    for (int i = 1; i <= 5; i++) begin
      rst = (i == 5);
      settle();
      if (i == 5) begin
        $display("rst mid-div: pc_write=%0d ifid_flush=%0d idex_flush=%0d", pc_write_a, ifid_flush_a, idex_flush_a);
        check("rstdiv.pc_write", pc_write_a, 0);
        check("rstdiv.ifid_write", ifid_write_a, 0);
        check("rstdiv.ifid_flush", ifid_flush_a, 1);
        check("rstdiv.idex_flush", idex_flush_a, 1);
      end
      tick();
    end
    rst = 0;
    settle();
    $display("after rst: md_busy=%0d stall_count=%0d pc_write=%0d", md_busy_a, stall_count_a, pc_write_a);
    check("rstdiv_after.md_busy", md_busy_a, 0);
    check("rstdiv_after.stall_count", stall_count_a, 0);
    check("rstdiv_after.pc_write", pc_write_a, 1);
    tick();
    idle();

    // multiply starts in the same cycle as a taken branch
    md_start = 1; md_is_div = 0; branch_taken = 1;
    settle();
    $display("br+mul: pc_write=%0d ifid_flush=%0d", pc_write_a, ifid_flush_a);
    check("brmul.pc_write", pc_write_a, 1);
    check("brmul.ifid_flush", ifid_flush_a, 1);
    tick();
    idle();
    settle();
    $display("br+mul next: md_busy=%0d pc_write=%0d", md_busy_a, pc_write_a);
    check("brmul_next.md_busy", md_busy_a, 1);
    check("brmul_next.pc_write", pc_write_a, 1);
    for (int i = 0; i < 4; i++) tick();
    settle();
    $display("br+mul end: md_busy=%0d", md_busy_a);
    check("brmul_end.md_busy", md_busy_a, 0);
    tick();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
